regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: A (ALU result) and B (load/memory result). It uses valid/ready handshakes and round-robin arbitration on conflicts. It suppresses writes to x0 and registers the granted write before it reaches the register file's `addressw`/`writeData`/`writeEn` pins. It sits between the execute/memory writeback paths and the register file and also exposes a saturating conflict counter for performance debug.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 50 +++++
 rtl/regfile_write_arbiter.sv | 90 +++++++++
 tb/tb_regfile_write_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register file constants and requester ids.
// Imported by the register file and its write-port arbiter.
package regfile_pkg;

  localparam int DEPTH  = 32;
  localparam int BITS   = 64;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a single priority bit.
// Flush suppresses grants and returns priority to requester A.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       flush,
  output logic [1:0] gnt,
  output logic       conflict
);

  req_id_t r_prio;
  req_id_t w_prio_nxt;

  always_comb begin
    gnt        = 2'b00;
    conflict   = 1'b0;
    w_prio_nxt = r_prio;
    if (flush) begin
      w_prio_nxt = REQ_A;
    end else begin
      unique case (req)
        2'b11: begin
          conflict = 1'b1;
          gnt = (r_prio == REQ_A) ? 2'b01 : 2'b10;
        end
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        default: gnt = 2'b00;
      endcase
      // Priority moves to whichever side was not served.
      if (gnt[0]) begin
        w_prio_nxt = REQ_B;
      end else if (gnt[1]) begin
        w_prio_nxt = REQ_A;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= REQ_A;
    end else begin
      r_prio <= w_prio_nxt;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU and load writeback.
// Drops x0 writes, registers the winner, counts conflict cycles.
module regfile_write_arbiter #(
  parameter int DEPTH = 32,
  parameter int BITS  = 64,
  parameter int CNT_W = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [BITS-1:0]   a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [BITS-1:0]   b_data,
  output logic              b_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] addressw,
  output logic [BITS-1:0]   writeData,
  output logic              writeEn,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_count
);

  import regfile_pkg::*;

  logic w_real_a;
  logic w_real_b;
  logic w_null_a;
  logic w_null_b;
  logic [1:0] w_gnt;
  logic w_conflict;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [BITS-1:0]   r_data;
  req_id_t           r_last;
  logic [CNT_W-1:0]  r_cnt;

  assign w_real_a = rst_n & a_valid & (a_addr != '0);
  assign w_real_b = rst_n & b_valid & (b_addr != '0);
  assign w_null_a = a_valid & (a_addr == '0);
  assign w_null_b = b_valid & (b_addr == '0);

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({w_real_b, w_real_a}),
    .flush    (flush),
    .gnt      (w_gnt),
    .conflict (w_conflict)
  );

  // Null requests are acked without touching the arbiter.
  assign a_ready = rst_n & ~flush & (w_null_a | w_gnt[0]);
  assign b_ready = rst_n & ~flush & (w_null_b | w_gnt[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_last <= REQ_A;
      r_cnt  <= '0;
    end else begin
      r_we <= |w_gnt;
      if (w_gnt[0]) begin
        r_addr <= a_addr;
        r_data <= a_data;
        r_last <= REQ_A;
      end else if (w_gnt[1]) begin
        r_addr <= b_addr;
        r_data <= b_data;
        r_last <= REQ_B;
      end
      if (w_conflict && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign writeEn        = r_we;
  assign addressw       = r_addr;
  assign writeData      = r_data;
  assign last_grant     = r_last;
  assign conflict_count = r_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for the register file write arbiter.
// Grants push expected writes; a negedge monitor pops them.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int CW = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BITS-1:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a_valid = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [BITS-1:0] a_data = '0;
  logic a_ready;
  logic b_valid = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [BITS-1:0] b_data = '0;
  logic b_ready;
  logic flush = 1'b0;
  logic [ADDR_W-1:0] addressw;
  logic [BITS-1:0] writeData;
  logic writeEn;
  logic last_grant;
  logic [CW-1:0] conflict_count;

  wr_t sb[$];
  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(
    .DEPTH(DEPTH), .BITS(BITS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr),
    .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr),
    .b_data(b_data), .b_ready(b_ready),
    .flush(flush),
    .addressw(addressw), .writeData(writeData),
    .writeEn(writeEn), .last_grant(last_grant),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && writeEn) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_write got %0d<-%h want none",
                 addressw, writeData);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (addressw !== e.addr || writeData !== e.data) begin
          errors++;
          $display("FAIL write got %0d<-%h want %0d<-%h",
                   addressw, writeData, e.addr, e.data);
        end
      end
    end
  end

  task automatic drv(
    input logic av, input logic [ADDR_W-1:0] aa,
    input logic [BITS-1:0] ad,
    input logic bv, input logic [ADDR_W-1:0] ba,
    input logic [BITS-1:0] bd, input logic fl
  );
    @(posedge clk);
    #1;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    flush = fl;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [ADDR_W-1:0] ad,
                      input logic [BITS-1:0] d);
    wr_t e;
    e.addr = ad;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    a_valid = 1'b1; a_addr = 5; a_data = 64'h55;
    #2;
    checks++;
    if (writeEn !== 1'b0 || addressw !== '0 ||
        writeData !== '0) begin
      errors++;
      $display("FAIL reset_out got we=%b a=%0d d=%h want 0",
               writeEn, addressw, writeData);
    end
    checks++;
    if (last_grant !== 1'b0 || conflict_count !== '0) begin
      errors++;
      $display("FAIL reset_state got lg=%b cnt=%0d want 0",
               last_grant, conflict_count);
    end
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b%b want 00",
               a_ready, b_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    a_valid = 1'b0;
  endtask

  task automatic test_single();
    drv(1, 5, 64'h1234, 0, 0, 0, 0);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready got %b%b want 10",
               a_ready, b_ready);
    end
    push(5, 64'h1234);
    idle(1);
    checks++;
    if (writeEn !== 1'b1 || last_grant !== 1'b0) begin
      errors++;
      $display("FAIL single_we got we=%b lg=%b want 1 0",
               writeEn, last_grant);
    end
    idle(1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL single_drain got %0d left want 0",
               sb.size());
    end
  endtask

  task automatic test_conflict();
    do_reset();
    drv(1, 3, 64'hA, 1, 4, 64'hB, 0);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL conf_c0 got %b%b want 10",
               a_ready, b_ready);
    end
    push(3, 64'hA);
    drv(0, 0, 0, 1, 4, 64'hB, 0);
    checks++;
    if (b_ready !== 1'b1 || last_grant !== 1'b0) begin
      errors++;
      $display("FAIL conf_c1 got b=%b lg=%b want 1 0",
               b_ready, last_grant);
    end
    push(4, 64'hB);
    idle(2);
    checks++;
    if (conflict_count !== 4'd1 || sb.size() != 0 ||
        last_grant !== 1'b1) begin
      errors++;
      $display("FAIL conf_end got cnt=%0d q=%0d lg=%b want 1 0 1",
               conflict_count, sb.size(), last_grant);
    end
  endtask

  task automatic test_sustained();
    logic [BITS-1:0] ad;
    logic [BITS-1:0] bd;
    ad = 64'hA0;
    bd = 64'hB0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, ad, 1, 2, bd, 0);
      checks++;
      if (a_ready !== (i % 2 == 0) ||
          b_ready !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL sust_%0d got %b%b", i, a_ready, b_ready);
      end
      if (i > 0) begin
        checks++;
        if (writeEn !== 1'b1) begin
          errors++;
          $display("FAIL sust_we_%0d got 0 want 1", i);
        end
      end
      if (i % 2 == 0) begin
        push(1, ad);
        ad = ad + 1;
      end else begin
        push(2, bd);
        bd = bd + 1;
      end
    end
    idle(2);
    checks++;
    if (conflict_count !== 4'd4 || sb.size() != 0) begin
      errors++;
      $display("FAIL sust_end got cnt=%0d q=%0d want 4 0",
               conflict_count, sb.size());
    end
  endtask

  task automatic test_x0();
    drv(1, 2, 64'h22, 0, 0, 0, 0);
    push(2, 64'h22);
    drv(0, 0, 0, 1, 0, 64'hDEAD, 0);
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL x0_null got %b%b want 01",
               a_ready, b_ready);
    end
    drv(1, 10, 64'hA10, 1, 11, 64'hB11, 0);
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_prio got %b%b want 01",
               a_ready, b_ready);
    end
    push(11, 64'hB11);
    drv(1, 0, 64'h1, 1, 7, 64'h77, 0);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_both got %b%b want 11",
               a_ready, b_ready);
    end
    push(7, 64'h77);
    drv(1, 12, 64'hA12, 1, 13, 64'hB13, 0);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL x0_after got %b%b want 10",
               a_ready, b_ready);
    end
    push(12, 64'hA12);
    idle(2);
    checks++;
    if (conflict_count !== 4'd6 || sb.size() != 0) begin
      errors++;
      $display("FAIL x0_end got cnt=%0d q=%0d want 6 0",
               conflict_count, sb.size());
    end
  endtask

  task automatic test_flush();
    drv(1, 6, 64'h66, 0, 0, 0, 0);
    push(6, 64'h66);
    drv(1, 8, 64'h88, 1, 9, 64'h99, 1);
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got %b%b want 00",
               a_ready, b_ready);
    end
    drv(1, 0, 64'h1, 0, 0, 0, 1);
    checks++;
    if (a_ready !== 1'b0 || writeEn !== 1'b0) begin
      errors++;
      $display("FAIL flush_null got r=%b we=%b want 0 0",
               a_ready, writeEn);
    end
    drv(1, 8, 64'h88, 1, 9, 64'h99, 0);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0 ||
        writeEn !== 1'b0) begin
      errors++;
      $display("FAIL flush_after got %b%b we=%b want 10 0",
               a_ready, b_ready, writeEn);
    end
    push(8, 64'h88);
    drv(0, 0, 0, 1, 9, 64'h99, 0);
    push(9, 64'h99);
    idle(2);
    checks++;
    if (conflict_count !== 4'd7 || sb.size() != 0) begin
      errors++;
      $display("FAIL flush_end got cnt=%0d q=%0d want 7 0",
               conflict_count, sb.size());
    end
  endtask

  task automatic test_saturate();
    logic [BITS-1:0] ad;
    logic [BITS-1:0] bd;
    ad = 64'h100;
    bd = 64'h200;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drv(1, 20, ad, 1, 21, bd, 0);
      if (i % 2 == 0) begin
        push(20, ad);
        ad = ad + 1;
      end else begin
        push(21, bd);
        bd = bd + 1;
      end
    end
    idle(2);
    checks++;
    if (conflict_count !== 4'd15 || sb.size() != 0) begin
      errors++;
      $display("FAIL saturate got cnt=%0d q=%0d want 15 0",
               conflict_count, sb.size());
    end
  endtask

  task automatic test_reset_mid_write();
    drv(1, 9, 64'h99, 0, 0, 0, 0);
    push(9, 64'h99);
    drv(1, 5, 64'h55, 0, 0, 0, 0);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_accept got %b want 1", a_ready);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (writeEn !== 1'b0 || addressw !== '0 ||
        writeData !== '0 || conflict_count !== '0) begin
      errors++;
      $display("FAIL mid_reset got we=%b a=%0d d=%h c=%0d",
               writeEn, addressw, writeData, conflict_count);
    end
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_ready got %b want 0", a_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    a_valid = 1'b0;
    idle(2);
    checks++;
    if (sb.size() != 0 || writeEn !== 1'b0) begin
      errors++;
      $display("FAIL mid_end got q=%0d we=%b want 0 0",
               sb.size(), writeEn);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_sustained();
    test_x0();
    test_flush();
    test_saturate();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
